// File: rtl/channel_deskew_pkg.sv
// channel_deskew_pkg
//   Shared definitions for the channel deskew block: default geometry and the
//   acquisition FSM state encoding.
package channel_deskew_pkg;

  localparam int N_DEF        = 10;
  localparam int CH_DEF       = 3;
  localparam int MAX_SKEW_DEF = 3;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    COLLECT = 2'd1,
    LOAD    = 2'd2,
    LOCKED  = 2'd3
  } state_t;

endpackage

// File: rtl/channel_deskew_var_delay.sv
// channel_deskew_var_delay
//   Programmable delay line for one channel: circular buffer plus output
//   register. odata follows idata by exactly 1+delay ce-cycles.
// Ports
//   clk, rst  clock, synchronous active-high reset
//   ce        clock enable; ce=0 freezes buffer, pointer and output
//   delay     extra delay in ce-cycles (0..DEPTH-1)
//   idata     {mark, data} input
//   odata     {mark, data} output, registered
module channel_deskew_var_delay #(
  parameter int W     = 11,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [AW-1:0] delay,
  input  logic [W-1:0]  idata,
  output logic [W-1:0]  odata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   sum;
  logic [W-1:0]  rd;

  // mem[wp-1] holds the previous ce-cycle's input, so reading wp-delay gives
  // delay cycles of history; delay=0 bypasses the buffer straight into odata.
  always_comb begin
    sum = {1'b0, wp} + DEPTH_W - {1'b0, delay};
    if (sum >= DEPTH_W) sum = sum - DEPTH_W;
    rp = sum[AW-1:0];
    rd = (delay == '0) ? idata : mem[rp];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      odata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ce) begin
      mem[wp] <= idata;
      wp      <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      odata   <= rd;
    end
  end

endmodule

// File: rtl/channel_deskew.sv
// channel_deskew
//   Measures the arrival offset of one alignment mark per channel and delays
//   each channel so that all marks leave together.
// Ports
//   clk, rst  clock, synchronous active-high reset
//   ce        clock enable for all state
//   resync    force re-acquisition (with ce=1)
//   in_data   CH channels of N bits, channel k at [k*N +: N]
//   in_mark   one alignment mark per channel
//   out_data  deskewed data, registered
//   out_mark  deskewed marks, registered
//   aligned   high while LOCKED
//   skew_err  one-cycle pulse on acquisition timeout or loss of lock
//
// state   | meaning
// SEARCH  | idle, waiting for the first mark of a set
// COLLECT | counting ce-cycles, recording each channel's first arrival
// LOAD    | delays computed from arrivals, take effect next cycle
// LOCKED  | aligned; watching out_mark for misalignment
module channel_deskew
  import channel_deskew_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int CH       = CH_DEF,
  parameter int MAX_SKEW = MAX_SKEW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          resync,
  input  logic [N*CH-1:0] in_data,
  input  logic [CH-1:0] in_mark,
  output logic [N*CH-1:0] out_data,
  output logic [CH-1:0] out_mark,
  output logic          aligned,
  output logic          skew_err
);

  localparam int AW = $clog2(MAX_SKEW + 1);
  localparam logic [AW:0] MAX_W = (AW+1)'(MAX_SKEW);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [CH-1:0] seen;
  logic [AW-1:0] arr [CH];
  logic [AW-1:0] dly [CH];
  logic [N:0]    od  [CH];

  logic [CH-1:0] seen_nx;
  logic [AW:0]   cnt_inc;
  logic [AW-1:0] arr_max;

  always_comb begin
    seen_nx = seen | in_mark;
    cnt_inc = {1'b0, cnt} + 1'b1;
    arr_max = '0;
    for (int k = 0; k < CH; k++)
      if (arr[k] > arr_max) arr_max = arr[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      cnt      <= '0;
      seen     <= '0;
      aligned  <= 1'b0;
      skew_err <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        arr[k] <= '0;
        dly[k] <= '0;
      end
    end else if (ce) begin
      skew_err <= 1'b0;
      if (resync) begin
        state   <= SEARCH;
        aligned <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (|in_mark) begin
              cnt  <= '0;
              seen <= in_mark;
              for (int k = 0; k < CH; k++) arr[k] <= '0;
              state <= (&in_mark) ? LOAD : COLLECT;
            end
          end
          COLLECT: begin
            for (int k = 0; k < CH; k++)
              if (in_mark[k] && !seen[k]) arr[k] <= cnt_inc[AW-1:0];
            seen <= seen_nx;
            if (&seen_nx) begin
              state <= LOAD;
            end else if (cnt_inc >= MAX_W) begin
              // the next arrival would exceed MAX_SKEW, so give up now
              skew_err <= 1'b1;
              state    <= SEARCH;
            end else begin
              cnt <= cnt_inc[AW-1:0];
            end
          end
          LOAD: begin
            for (int k = 0; k < CH; k++) dly[k] <= arr_max - arr[k];
            aligned <= 1'b1;
            state   <= LOCKED;
          end
          LOCKED: begin
            if ((|out_mark) && !(&out_mark)) begin
              skew_err <= 1'b1;
              aligned  <= 1'b0;
              state    <= SEARCH;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    channel_deskew_var_delay #(
      .W     (N + 1),
      .DEPTH (MAX_SKEW + 1),
      .AW    (AW)
    ) u_dly (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .delay (dly[k]),
      .idata ({in_mark[k], in_data[k*N +: N]}),
      .odata (od[k])
    );
    assign out_data[k*N +: N] = od[k][N-1:0];
    assign out_mark[k]        = od[k][N];
  end

endmodule

// File: tb/tb_channel_deskew.sv
module tb_channel_deskew;

  localparam int N        = 10;
  localparam int CH       = 3;
  localparam int MAX_SKEW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic            resync;
  logic [N*CH-1:0] in_data;
  logic [CH-1:0]   in_mark;
  logic [N*CH-1:0] out_data;
  logic [CH-1:0]   out_mark;
  logic            aligned;
  logic            skew_err;

  channel_deskew #(.N(N), .CH(CH), .MAX_SKEW(MAX_SKEW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .resync   (resync),
    .in_data  (in_data),
    .in_mark  (in_mark),
    .out_data (out_data),
    .out_mark (out_mark),
    .aligned  (aligned),
    .skew_err (skew_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    int         ch;
    logic [N:0] v;
  } ent_t;

  ent_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cecnt = 0;
  bit         sb_en = 1'b0;
  int         skw  [CH];
  int         dexp [CH];
  logic [N:0] last_exp [CH];
  bit         have_exp [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: push expectations for this ce-cycle's input, then pop what is due.
  task automatic tick();
    logic ce_s;
    logic rst_s;
    ent_t e;
    int   k;
    ce_s  = ce;
    rst_s = rst;
    if (sb_en && ce && !rst) begin
      for (int c = 0; c < CH; c++) begin
        e.t  = cecnt + 1 + dexp[c];
        e.ch = c;
        e.v  = {in_mark[c], in_data[c*N +: N]};
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (rst_s) begin
      sbq.delete();
      for (int c = 0; c < CH; c++) have_exp[c] = 1'b0;
    end else if (ce_s) begin
      cecnt++;
      for (int c = 0; c < CH; c++) have_exp[c] = 1'b0;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].t <= cecnt) begin
          k = sbq[i].ch;
          if (sbq[i].t < cecnt)
            chk("sb_late", 32'(sbq[i].t), 32'(cecnt));
          else begin
            chk($sformatf("sb_ch%0d", k), 32'({out_mark[k], out_data[k*N +: N]}), 32'(sbq[i].v));
            last_exp[k] = sbq[i].v;
            have_exp[k] = 1'b1;
          end
          sbq.delete(i);
        end
      end
    end else begin
      for (int c = 0; c < CH; c++)
        if (have_exp[c])
          chk($sformatf("hold_ch%0d", c), 32'({out_mark[c], out_data[c*N +: N]}), 32'(last_exp[c]));
    end
  endtask

  // Present one mark set with offsets skw[]; gap inserts a ce=0 cycle with junk marks before each.
  task automatic acq(input bit gap);
    int mx;
    mx = 0;
    for (int c = 0; c < CH; c++) if (skw[c] > mx) mx = skw[c];
    for (int j = 0; j <= mx; j++) begin
      if (gap) begin
        ce = 1'b0; in_mark = CH'($urandom); tick(); ce = 1'b1;
      end
      in_data = (N*CH)'($urandom);
      for (int c = 0; c < CH; c++) in_mark[c] = (skw[c] == j);
      tick();
    end
    in_mark = '0;
    chk("acq_aligned_lo", 32'(aligned), 32'd0);
    if (gap) begin
      ce = 1'b0; in_mark = CH'($urandom); tick(); ce = 1'b1; in_mark = '0;
    end
    tick();
    chk("acq_aligned_hi", 32'(aligned), 32'd1);
  endtask

  // Stream random data (and periodic skewed mark sets) through the scoreboard, then drain.
  task automatic window(input int nt, input bit marks, input bit exp_al, input bit ce_rand);
    int ph;
    ph    = 0;
    sb_en = 1'b1;
    for (int i = 0; i < nt; i++) begin
      ce      = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = (N*CH)'($urandom);
      in_mark = '0;
      if (ce) begin
        if (marks) for (int c = 0; c < CH; c++) in_mark[c] = (ph == skw[c]);
        ph = (ph + 1) % 8;
      end else begin
        in_mark = CH'($urandom);
      end
      tick();
      chk("win_aligned", 32'(aligned), 32'(exp_al));
      chk("win_skew_err", 32'(skew_err), 32'd0);
    end
    sb_en   = 1'b0;
    ce      = 1'b1;
    in_mark = '0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_mark"}, 32'(out_mark), 32'd0);
    chk({tag, "_aligned"}, 32'(aligned), 32'd0);
    chk({tag, "_skew_err"}, 32'(skew_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ce = 1'b1; resync = 1'b0; in_data = '0; in_mark = '0;
    for (int c = 0; c < CH; c++) begin have_exp[c] = 1'b0; dexp[c] = 0; skw[c] = 0; end
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;

    // zero skew
    skw = '{0, 0, 0}; dexp = '{0, 0, 0};
    acq(1'b0);
    window(24, 1'b1, 1'b1, 1'b0);

    // resync from LOCKED
    resync = 1'b1; tick(); resync = 1'b0;
    chk("resync_aligned", 32'(aligned), 32'd0);
    chk("resync_skew_err", 32'(skew_err), 32'd0);
    tick();
    chk("resync_skew_err2", 32'(skew_err), 32'd0);

    // skew 0,2,1
    skw = '{0, 2, 1};
    acq(1'b0);
    dexp = '{2, 0, 1};
    window(24, 1'b1, 1'b1, 1'b0);

    // largest correctable skew
    resync = 1'b1; tick(); resync = 1'b0;
    skw = '{0, 3, 1};
    acq(1'b0);
    dexp = '{3, 0, 2};
    window(24, 1'b1, 1'b1, 1'b0);

    // loss of lock: stray ch1 mark (ch1 delay 0)
    in_mark = 3'b010; tick(); in_mark = '0;
    chk("lol_pre", 32'(skew_err), 32'd0);
    tick();
    chk("lol_pulse", 32'(skew_err), 32'd1);
    chk("lol_aligned", 32'(aligned), 32'd0);
    tick();
    chk("lol_end", 32'(skew_err), 32'd0);
    acq(1'b0);
    window(24, 1'b1, 1'b1, 1'b0);

    // timeout; delays back to 0 after reset
    rst = 1'b1; tick(); rst = 1'b0;
    dexp = '{0, 0, 0};
    window(8, 1'b0, 1'b0, 1'b0);
    in_mark = 3'b001; tick(); in_mark = '0;
    chk("to_c0", 32'(skew_err), 32'd0);
    tick(); chk("to_c1", 32'(skew_err), 32'd0);
    tick(); chk("to_c2", 32'(skew_err), 32'd0);
    tick(); chk("to_pulse", 32'(skew_err), 32'd1);
    chk("to_aligned", 32'(aligned), 32'd0);
    tick(); chk("to_end", 32'(skew_err), 32'd0);
    skw = '{0, 0, 0};
    acq(1'b0);
    window(16, 1'b1, 1'b1, 1'b0);

    // ce gating during acquisition and streaming
    rst = 1'b1; tick(); rst = 1'b0;
    skw = '{0, 2, 1};
    acq(1'b1);
    dexp = '{2, 0, 1};
    window(48, 1'b1, 1'b1, 1'b1);

    // reset in LOCKED with ce=0
    in_data = 30'h2AB5_5A5A; tick(); tick();
    rst = 1'b1; ce = 1'b0; tick(); rst = 1'b0; ce = 1'b1;
    chk_zero("rst_locked");

    // reset in COLLECT
    in_mark = 3'b001; in_data = 30'h1234_5678; tick(); in_mark = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk_zero("rst_collect");
    dexp = '{0, 0, 0};
    window(8, 1'b0, 1'b0, 1'b0);
    skw = '{0, 0, 0};
    acq(1'b0);
    window(16, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
